time_set_ctrl: RTL
==================

TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 Parameter REPEAT_DLY, default 16, gives the number of cycles btn_inc is held before the first auto-repeat increment.
REQ-002 Parameter REPEAT_PER, default 4, gives the number of cycles between later auto-repeat increments.
REQ-003 Port clk  in  1  single clock; all logic on its rising edge.
REQ-004 Port rst_n  in  1  synchronous, active-low reset.
REQ-005 Port btn_mode  in  1  debounced, clk-synchronous level; rising edge advances the edit state.
REQ-006 Port btn_inc  in  1  debounced, clk-synchronous level; rising edge increments the edited field.
REQ-007 Port QH  in  8  current hours from the clock counter, BCD {tens,units}.
REQ-008 Port QM  in  8  current minutes from the clock counter, BCD {tens,units}.
REQ-009 Port DI  out  7  load data to the counter: [6:4] tens, [3:0] units.
REQ-010 Port L  out  1  load strobe to the counter.
REQ-011 Port H_M  out  1  load select: 0 = hours, 1 = minutes; the counter loads minutes on L&H_M and hours on L&!H_M.
REQ-012 Port ce_hold  out  1  1 = counter count-enable must be blocked externally.
REQ-013 Port edit_val  out  8  BCD value currently being edited, for display.
REQ-014 Port st  out  2  state code: RUN=0, EDIT_H=1, EDIT_M=2, COMMIT=3.

Function
REQ-015 The block SHALL register btn_mode and btn_inc each cycle, and define a rising edge as the current input high while its registered copy is low.
REQ-016 In RUN, a btn_mode edge SHALL move to EDIT_H on that clock edge and capture hr_r<=QH and min_r<=QM.
REQ-017 In EDIT_H, a btn_inc edge SHALL increment hr_r in BCD: units 9 -> 0 with a tens carry, and 23 -> 00.
REQ-018 In EDIT_H, a btn_mode edge SHALL move to EDIT_M.
REQ-019 In EDIT_M, a btn_inc edge SHALL increment min_r in BCD: units 9 -> 0 with a tens carry, and 59 -> 00.
REQ-020 In EDIT_M, a btn_mode edge SHALL move to COMMIT.
REQ-021 If btn_mode and btn_inc edges arrive in the same cycle, the btn_mode edge SHALL take effect and the increment SHALL be dropped.
REQ-022 COMMIT SHALL last exactly 2 cycles, then return to RUN.
REQ-023 COMMIT phase 0 SHALL drive L=1, H_M=0, DI=hr_r[6:0].
REQ-024 COMMIT phase 1 SHALL drive L=1, H_M=1, DI=min_r[6:0].
REQ-025 Both buttons SHALL be ignored during COMMIT.
REQ-026 Outside COMMIT, the block SHALL drive L=0, H_M=0, DI=0.
REQ-027 ce_hold SHALL be 1 in EDIT_H, EDIT_M and COMMIT, and 0 in RUN.
REQ-028 edit_val SHALL equal hr_r in EDIT_H, min_r in EDIT_M, and 8'h00 otherwise.
REQ-029 hr_r[7] and min_r[7] SHALL always be 0.
REQ-030 All outputs SHALL be decoded from registered state only (Moore); no input-to-output combinational path.

Reset
REQ-031 With rst_n=0 at a clock edge, the block SHALL set: state RUN, COMMIT phase 0, hr_r=0, min_r=0, button registers 0, repeat counter 0.
REQ-032 After that edge the outputs SHALL be L=0, H_M=0, DI=0, ce_hold=0, edit_val=0, st=0.
REQ-033 If reset is asserted during COMMIT, no further L pulse SHALL be issued; any field already loaded into the counter stays loaded.

Configuration
REQ-034 With macro TIME_SET_AUTOREPEAT_EN defined, holding btn_inc high in EDIT_H or EDIT_M SHALL produce one increment at the edge, another after REPEAT_DLY held cycles, then one every REPEAT_PER held cycles.
REQ-035 The repeat counter SHALL clear on btn_inc low or on any state change.
REQ-036 With TIME_SET_AUTOREPEAT_EN undefined, increments SHALL occur only on btn_inc rising edges, and the repeat counter and the REPEAT_* parameters SHALL have no effect.

Verification
REQ-037 Reset test: rst_n=0 for 2 cycles mid-EDIT_M -> st=0, L=0, ce_hold=0, edit_val=8'h00.
REQ-038 Hours wrap: QH=8'h09, QM=8'h58; mode; inc -> edit_val=8'h10; 14 more inc -> 8'h24 is never shown, 8'h23 -> 8'h00.
REQ-039 Full set: QH=8'h22, QM=8'h58; mode, inc, mode, inc, inc, mode -> COMMIT cycle 1: L=1, H_M=0, DI=7'h23; cycle 2: L=1, H_M=1, DI=7'h00; cycle 3: L=0, st=0, ce_hold=0.
REQ-040 Simultaneous edges: in EDIT_H with hr_r=8'h05, assert mode and inc in the same cycle -> st=2, hr_r stays 8'h05.
REQ-041 Reset during commit: assert rst_n=0 in COMMIT phase 0 -> next cycle L=0, st=0, and no minutes load occurs.
REQ-042 Hold test: btn_inc held 25 cycles in EDIT_M from min_r=8'h00 -> 8'h01 without the macro; 8'h04 with the macro, REPEAT_DLY=16, REPEAT_PER=4.

Source files
------------

// File: rtl/time_set_ctrl.sv
// Clock time-set FSM: RUN -> EDIT_H -> EDIT_M -> COMMIT (two load cycles) -> RUN; Moore outputs, one-cycle response, no backpressure.
// Optional hold-to-repeat on btn_inc is enabled by defining TIME_SET_AUTOREPEAT_EN.
module time_set_ctrl #(
    parameter int REPEAT_DLY = 16,
    parameter int REPEAT_PER = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic [7:0] QH,
    input  logic [7:0] QM,
    output logic [6:0] DI,
    output logic       L,
    output logic       H_M,
    output logic       ce_hold,
    output logic [7:0] edit_val,
    output logic [1:0] st
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        EDIT_H = 2'd1,
        EDIT_M = 2'd2,
        COMMIT = 2'd3
    } state_t;

    if (REPEAT_DLY < 1 || REPEAT_PER < 1) begin : g_bad_params
        $error("time_set_ctrl: REPEAT_DLY and REPEAT_PER must be at least 1");
    end

    state_t     state_q, state_d;
    logic       phase_q, phase_d;
    logic [7:0] hr_q, hr_d;
    logic [7:0] min_q, min_d;
    logic       mode_q, inc_q;
    logic       mode_edge, inc_edge, inc_fire;

    // Values at or above the top (including malformed captures) wrap to 00.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
        if (v >= top) begin
            return 8'h00;
        end else if (v[3:0] >= 4'd9) begin
            return {1'b0, v[6:4] + 3'd1, 4'd0};
        end else begin
            return {1'b0, v[6:4], v[3:0] + 4'd1};
        end
    endfunction

`ifdef TIME_SET_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d, rpt_next, rpt_target;
    logic             rpt_armed_q, rpt_armed_d;
    logic             rpt_fire;
`endif

    always_comb begin
        mode_edge = btn_mode & ~mode_q;
        inc_edge  = btn_inc & ~inc_q;
        state_d   = state_q;
        phase_d   = phase_q;
        hr_d      = hr_q;
        min_d     = min_q;
        inc_fire  = inc_edge;

`ifdef TIME_SET_AUTOREPEAT_EN
        // Counter tracks held cycles; first target is REPEAT_DLY, then REPEAT_PER once armed.
        rpt_fire    = 1'b0;
        rpt_cnt_d   = '0;
        rpt_armed_d = 1'b0;
        rpt_next    = rpt_cnt_q + 1'b1;
        rpt_target  = rpt_armed_q ? RPT_W'(REPEAT_PER) : RPT_W'(REPEAT_DLY);
        if ((state_q == EDIT_H || state_q == EDIT_M) && btn_inc && inc_q) begin
            if (rpt_next == rpt_target) begin
                rpt_fire    = 1'b1;
                rpt_armed_d = 1'b1;
            end else begin
                rpt_cnt_d   = rpt_next;
                rpt_armed_d = rpt_armed_q;
            end
        end
        inc_fire = inc_edge | rpt_fire;
`endif

        case (state_q)
            RUN: begin
                if (mode_edge) begin
                    state_d = EDIT_H;
                    hr_d    = QH & 8'h7F;
                    min_d   = QM & 8'h7F;
                end
            end
            EDIT_H: begin
                if (mode_edge) begin
                    state_d = EDIT_M;
                end else if (inc_fire) begin
                    hr_d = bcd_inc(hr_q, 8'h23);
                end
            end
            EDIT_M: begin
                if (mode_edge) begin
                    state_d = COMMIT;
                    phase_d = 1'b0;
                end else if (inc_fire) begin
                    min_d = bcd_inc(min_q, 8'h59);
                end
            end
            default: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    state_d = RUN;
                end
            end
        endcase

`ifdef TIME_SET_AUTOREPEAT_EN
        if (state_d != state_q) begin
            rpt_cnt_d   = '0;
            rpt_armed_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
            phase_q <= 1'b0;
            hr_q    <= 8'h00;
            min_q   <= 8'h00;
            mode_q  <= 1'b0;
            inc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            hr_q    <= hr_d;
            min_q   <= min_d;
            mode_q  <= btn_mode;
            inc_q   <= btn_inc;
        end
    end

`ifdef TIME_SET_AUTOREPEAT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rpt_cnt_q   <= '0;
            rpt_armed_q <= 1'b0;
        end else begin
            rpt_cnt_q   <= rpt_cnt_d;
            rpt_armed_q <= rpt_armed_d;
        end
    end
`endif

    always_comb begin
        st       = state_q;
        ce_hold  = (state_q != RUN);
        L        = (state_q == COMMIT);
        H_M      = (state_q == COMMIT) & phase_q;
        DI       = 7'h00;
        edit_val = 8'h00;
        case (state_q)
            EDIT_H:  edit_val = hr_q;
            EDIT_M:  edit_val = min_q;
            COMMIT:  DI = phase_q ? min_q[6:0] : hr_q[6:0];
            default: ;
        endcase
    end

endmodule
